// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: FSM state encoding,
// alarm-time field limits and a wrap-around increment helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] HOUR_MAX = 8'd23;

  function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max);
    return (value == max) ? 8'd0 : value + 8'd1;
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Timer, button and alarm-status bundle between the alarm controller (slave)
// and whatever drives it (master).
interface alarm_ctrl_if;

  logic       sec_tick;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       alarm_en;
  logic       alarm_set;
  logic       set_min;
  logic       set_hour;
  logic       snooze;
  logic       stop;
  logic [7:0] alarm_min;
  logic [7:0] alarm_hour;
  logic       ringing;
  logic       snoozing;

  modport master (
    output sec_tick, seconds, minutes, hours,
    output alarm_en, alarm_set, set_min, set_hour, snooze, stop,
    input  alarm_min, alarm_hour, ringing, snoozing
  );

  modport slave (
    input  sec_tick, seconds, minutes, hours,
    input  alarm_en, alarm_set, set_min, set_hour, snooze, stop,
    output alarm_min, alarm_hour, ringing, snoozing
  );

endinterface

// File: rtl/alarm_ctrl_edge_pulse.sv
// edge_pulse: registers a button level once and emits a one-cycle pulse on its
// rising edge; a held button yields exactly one pulse.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic cur;
  logic prev;

  // NOTE: non-blocking assignments make cur/prev shift as a true two-stage pipe;
  // blocking here would copy the new cur straight into prev and kill the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= in;
      prev <= cur;
    end
  end

  assign pulse = cur & ~prev;

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: stores an alarm time, rings when the timer hits it, and handles
// snooze/stop/timeout. Define ALARM_SNOOZE_LIMIT_EN to cap snoozes per alarm at MAX_SNOOZE.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 540,
  parameter int MAX_SNOOZE  = 3
) (
  input logic         clk,
  input logic         reset,
  alarm_ctrl_if.slave bus
);

  localparam int RING_W = $clog2(RING_SECS);
  localparam int SNZ_W  = $clog2(SNOOZE_SECS);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SECS - 1);

  if (RING_SECS < 2 || SNOOZE_SECS < 2 || MAX_SNOOZE < 1) begin : g_param_check
    $error("alarm_ctrl: RING_SECS/SNOOZE_SECS must be >= 2 and MAX_SNOOZE >= 1");
  end

  alarm_state_t      state, state_next;
  logic [RING_W-1:0] ring_cnt, ring_cnt_next;
  logic [SNZ_W-1:0]  snz_cnt, snz_cnt_next;
  logic [7:0]        alarm_min_q, alarm_hour_q;
  logic              min_p, hour_p, snooze_p, stop_p;
  logic              match, trigger, snooze_ok;

  edge_pulse u_min    (.clk(clk), .reset(reset), .in(bus.set_min),  .pulse(min_p));
  edge_pulse u_hour   (.clk(clk), .reset(reset), .in(bus.set_hour), .pulse(hour_p));
  edge_pulse u_snooze (.clk(clk), .reset(reset), .in(bus.snooze),   .pulse(snooze_p));
  edge_pulse u_stop   (.clk(clk), .reset(reset), .in(bus.stop),     .pulse(stop_p));

  // seconds==0 appears on a single tick per minute, so a match fires only once.
  assign match   = (bus.hours == alarm_hour_q) && (bus.minutes == alarm_min_q) &&
                   (bus.seconds == 8'd0);
  assign trigger = bus.sec_tick && match && bus.alarm_en && !bus.alarm_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_min_q  <= 8'd0;
      alarm_hour_q <= 8'd0;
    end else if (bus.alarm_set) begin
      if (min_p)  alarm_min_q  <= wrap_inc(alarm_min_q, MIN_MAX);
      if (hour_p) alarm_hour_q <= wrap_inc(alarm_hour_q, HOUR_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      state    <= state_next;
      ring_cnt <= ring_cnt_next;
      snz_cnt  <= snz_cnt_next;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_next    = state;
    ring_cnt_next = ring_cnt;
    snz_cnt_next  = snz_cnt;
    if (!bus.alarm_en || bus.alarm_set) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_next    = RING;
            ring_cnt_next = '0;
          end
        end
        RING: begin
          if (stop_p) begin
            state_next = IDLE;
          end else if (snooze_p && snooze_ok) begin
            state_next   = SNOOZE;
            snz_cnt_next = '0;
          end else if (bus.sec_tick) begin
            if (ring_cnt == RING_LAST) state_next = IDLE;
            else                       ring_cnt_next = ring_cnt + RING_W'(1);
          end
        end
        SNOOZE: begin
          if (stop_p) begin
            state_next = IDLE;
          end else if (bus.sec_tick) begin
            if (snz_cnt == SNZ_LAST) begin
              state_next    = RING;
              ring_cnt_next = '0;
            end else begin
              snz_cnt_next = snz_cnt + SNZ_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int SC_W = $clog2(MAX_SNOOZE + 1);
  logic [SC_W-1:0] snz_used;

  // Returning to IDLE starts a fresh alarm event with a full snooze allowance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  snz_used <= '0;
    else if (state_next == IDLE)                 snz_used <= '0;
    else if (state == RING && state_next == SNOOZE) snz_used <= snz_used + SC_W'(1);
  end

  assign snooze_ok = (snz_used != SC_W'(MAX_SNOOZE));
`else
  assign snooze_ok = 1'b1;
`endif

  assign bus.alarm_min  = alarm_min_q;
  assign bus.alarm_hour = alarm_hour_q;
  assign bus.ringing    = (state == RING);
  assign bus.snoozing   = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: table-driven alarm-time setting, directed
// trigger/timeout/snooze/reset sequences, and randomized traffic against a reference model.
module tb_alarm_ctrl;

  localparam int RING_SECS   = 60;
  localparam int SNOOZE_SECS = 540;
  localparam int MAX_SNOOZE  = 3;
  localparam int QUIET = 0, RINGING = 1, SNOOZING = 2;
`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam bit LIMITED = 1'b1;
`else
  localparam bit LIMITED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  alarm_ctrl_if bus ();

  alarm_ctrl #(
    .RING_SECS  (RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";
  int    t_h, t_m, t_s;

  // Reference model: mode, seconds left in the current phase, snoozes used,
  // alarm time, and the button levels seen one and two clock edges ago.
  int       m_mode, m_left, m_used, m_amin, m_ahour;
  bit [3:0] hist1, hist2, m_p;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d, expected %0d at %0t", phase, name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = QUIET; m_left = 0; m_used = 0; m_amin = 0; m_ahour = 0;
    hist1 = '0; hist2 = '0;
  endtask

  // Called exactly at each rising edge while reset is released; reads only the inputs.
  task automatic model_step();
    m_p   = hist1 & ~hist2;
    hist2 = hist1;
    hist1 = {bus.stop, bus.snooze, bus.set_hour, bus.set_min};
    if (bus.alarm_set) begin
      if (m_p[0]) m_amin  = (m_amin + 1) % 60;
      if (m_p[1]) m_ahour = (m_ahour + 1) % 24;
    end
    if (!bus.alarm_en || bus.alarm_set) begin
      m_mode = QUIET;
    end else if (m_mode == QUIET) begin
      if (bus.sec_tick && int'(bus.hours) == m_ahour && int'(bus.minutes) == m_amin &&
          int'(bus.seconds) == 0) begin
        m_mode = RINGING; m_left = RING_SECS;
      end
    end else if (m_p[3]) begin
      m_mode = QUIET;
    end else if (m_mode == RINGING) begin
      if (m_p[2] && (!LIMITED || m_used < MAX_SNOOZE)) begin
        m_mode = SNOOZING; m_left = SNOOZE_SECS; m_used++;
      end else if (bus.sec_tick) begin
        m_left--;
        if (m_left == 0) m_mode = QUIET;
      end
    end else if (bus.sec_tick) begin
      m_left--;
      if (m_left == 0) begin m_mode = RINGING; m_left = RING_SECS; end
    end
    if (m_mode == QUIET) m_used = 0;
  endtask

  task automatic check_model();
    check("ringing",    8'(bus.ringing),    8'(m_mode == RINGING));
    check("snoozing",   8'(bus.snoozing),   8'(m_mode == SNOOZING));
    check("alarm_min",  bus.alarm_min,      8'(m_amin));
    check("alarm_hour", bus.alarm_hour,     8'(m_ahour));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_step();
    #1;
    check_model();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_h = h; t_m = m; t_s = s;
    bus.hours = 8'(h); bus.minutes = 8'(m); bus.seconds = 8'(s);
  endtask

  task automatic tick_sec();
    t_s++;
    if (t_s == 60) begin t_s = 0; t_m++; end
    if (t_m == 60) begin t_m = 0; t_h = (t_h + 1) % 24; end
    set_time(t_h, t_m, t_s);
    bus.sec_tick = 1'b1;
    cyc();
    bus.sec_tick = 1'b0;
    cyc();
  endtask

  // b = {stop, snooze, set_hour, set_min}; one cycle high, one cycle low.
  task automatic press(input bit [3:0] b);
    {bus.stop, bus.snooze, bus.set_hour, bus.set_min} = b;
    cyc();
    {bus.stop, bus.snooze, bus.set_hour, bus.set_min} = 4'b0000;
    cyc();
  endtask

  task automatic ring_at_alarm(input string name);
    set_time(7, 29, 59);
    cyc();
    tick_sec();
    check(name, 8'(bus.ringing), 8'd1);
  endtask

  typedef struct {
    bit set;
    int n_min;
    int n_hour;
    int exp_min;
    int exp_hour;
  } set_vec_t;

  set_vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cumulative from reset: each row's expectation builds on the previous row.
    vecs[0] = '{1'b1, 25,  3, 25, 3};
    vecs[1] = '{1'b1, 35,  0,  0, 3};
    vecs[2] = '{1'b0,  5,  5,  0, 3};
    vecs[3] = '{1'b1, 59, 21, 59, 0};
    vecs[4] = '{1'b1,  1,  0,  0, 0};
    vecs[5] = '{1'b1, 60,  0,  0, 0};

    reset = 1'b0;
    bus.sec_tick = 1'b0; bus.alarm_en = 1'b1; bus.alarm_set = 1'b0;
    bus.set_min = 1'b0; bus.set_hour = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;
    set_time(12, 0, 30);
    model_reset();
    #12;
    phase = "reset";
    check("ringing",    8'(bus.ringing),  8'd0);
    check("snoozing",   8'(bus.snoozing), 8'd0);
    check("alarm_min",  bus.alarm_min,    8'd0);
    check("alarm_hour", bus.alarm_hour,   8'd0);
    @(negedge clk);
    reset = 1'b1;

    phase = "set_table";
    for (int r = 0; r < 6; r++) begin
      bus.alarm_set = vecs[r].set;
      for (int i = 0; i < ((vecs[r].n_min > vecs[r].n_hour) ? vecs[r].n_min : vecs[r].n_hour); i++)
        press({2'b00, 1'(i < vecs[r].n_hour), 1'(i < vecs[r].n_min)});
      check($sformatf("row%0d_min", r),  bus.alarm_min,  8'(vecs[r].exp_min));
      check($sformatf("row%0d_hour", r), bus.alarm_hour, 8'(vecs[r].exp_hour));
    end

    phase = "held_button";
    bus.alarm_set = 1'b1;
    bus.set_min   = 1'b1;
    repeat (8) cyc();
    bus.set_min = 1'b0;
    cyc(); cyc();
    check("one_step", bus.alarm_min, 8'd1);

    phase = "set_0730";
    for (int i = 0; i < 29; i++) press({2'b00, 1'(i < 7), 1'b1});
    bus.alarm_set = 1'b0;
    cyc();
    check("min",  bus.alarm_min,  8'd30);
    check("hour", bus.alarm_hour, 8'd7);

    phase = "trigger";
    bus.alarm_en = 1'b0;
    set_time(7, 29, 59);
    cyc();
    tick_sec();
    check("disarmed", 8'(bus.ringing), 8'd0);
    bus.alarm_en = 1'b1;
    set_time(7, 29, 59);
    cyc();
    set_time(7, 30, 0);
    bus.sec_tick = 1'b1;
    cyc();
    check("next_cycle", 8'(bus.ringing), 8'd1);
    bus.sec_tick = 1'b0;
    cyc();

    phase = "timeout";
    repeat (RING_SECS - 1) tick_sec();
    check("still_ringing", 8'(bus.ringing), 8'd1);
    tick_sec();
    check("expired", 8'(bus.ringing), 8'd0);
    repeat (3) tick_sec();
    check("no_rering", 8'(bus.ringing), 8'd0);

    phase = "snooze";
    ring_at_alarm("ring_start");
    press(4'b0100);
    check("snoozing", 8'(bus.snoozing), 8'd1);
    check("not_ringing", 8'(bus.ringing), 8'd0);
    repeat (SNOOZE_SECS - 1) tick_sec();
    check("still_snoozing", 8'(bus.snoozing), 8'd1);
    tick_sec();
    check("rering", 8'(bus.ringing), 8'd1);
    press(4'b0100);
    press(4'b1000);
    check("stop_snoozing", 8'(bus.snoozing), 8'd0);
    check("stop_ringing", 8'(bus.ringing), 8'd0);

    phase = "stop_beats_snooze";
    ring_at_alarm("ring_start");
    press(4'b1100);
    check("idle_ring", 8'(bus.ringing), 8'd0);
    check("idle_snz", 8'(bus.snoozing), 8'd0);

    phase = "override";
    ring_at_alarm("ring_start");
    bus.alarm_set = 1'b1;
    cyc();
    check("set_forces_idle", 8'(bus.ringing), 8'd0);
    bus.alarm_set = 1'b0;
    ring_at_alarm("ring_again");
    bus.alarm_en = 1'b0;
    cyc();
    check("disarm_forces_idle", 8'(bus.ringing), 8'd0);
    bus.alarm_en = 1'b1;

    phase = "snooze_limit";
    ring_at_alarm("ring_start");
    repeat (MAX_SNOOZE) begin
      press(4'b0100);
      repeat (SNOOZE_SECS) tick_sec();
    end
    check("ring_after_3", 8'(bus.ringing), 8'd1);
    press(4'b0100);
    check("fourth_snooze", 8'(bus.snoozing), LIMITED ? 8'd0 : 8'd1);
    check("fourth_ring",   8'(bus.ringing),  LIMITED ? 8'd1 : 8'd0);
    press(4'b1000);

    phase = "reset_mid_ring";
    ring_at_alarm("ring_start");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("ringing",    8'(bus.ringing), 8'd0);
    check("alarm_min",  bus.alarm_min,   8'd0);
    check("alarm_hour", bus.alarm_hour,  8'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick_sec();
    check("stays_idle", 8'(bus.ringing), 8'd0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      bus.sec_tick = ($urandom_range(0, 3) == 0);
      if (bus.sec_tick) begin
        if ($urandom_range(0, 7) == 0) set_time(m_ahour, m_amin, 0);
        else begin
          t_s++;
          if (t_s == 60) begin t_s = 0; t_m++; end
          if (t_m == 60) begin t_m = 0; t_h = (t_h + 1) % 24; end
          set_time(t_h, t_m, t_s);
        end
      end
      bus.alarm_en  = ($urandom_range(0, 127) != 0);
      bus.alarm_set = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 7) == 0)  bus.set_min  = ~bus.set_min;
      if ($urandom_range(0, 7) == 0)  bus.set_hour = ~bus.set_hour;
      if ($urandom_range(0, 7) == 0)  bus.snooze   = ~bus.snooze;
      if ($urandom_range(0, 19) == 0) bus.stop     = ~bus.stop;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
